// File: rtl/pe_ctrl_endpoint_if.sv
// Handshake bundle between one PE control endpoint and its environment
// (control center start/done tokens plus the memory read request channel).
//
// Every channel uses the same valid/ready rule: a transfer happens on a
// rising clock edge where valid and ready are both high; once valid is
// raised it stays high, with its data held stable, until that transfer.
interface pe_ctrl_endpoint_if #(
  parameter int ADDR_W = 8
);
  logic              start_valid;
  logic              start_ready;
  logic              start_data;
  logic              done_valid;
  logic              done_ready;
  logic              done_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_is_filt;

  // Environment side: control center and memory.
  modport master (
    output start_valid, start_data, done_ready, rd_ready,
    input  start_ready, done_valid, done_data, rd_valid, rd_addr, rd_is_filt
  );

  // Endpoint side.
  modport slave (
    input  start_valid, start_data, done_ready, rd_ready,
    output start_ready, done_valid, done_data, rd_valid, rd_addr, rd_is_filt
  );
endinterface

// File: rtl/pe_ctrl_endpoint.sv
// PE-side control token endpoint: takes one start token, issues the filter
// reads then the ifmap reads, counts the psums the PE emits, and returns one
// done token carrying the start flag once all psums are in.
module pe_ctrl_endpoint #(
  parameter int ADDR_W    = 8,
  parameter int FILT_BASE = 0,
  parameter int FILT_LEN  = 5,
  parameter int IFM_BASE  = 16,
  parameter int IFM_LEN   = 25,
  parameter int OUT_LEN   = 21,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_ctrl_endpoint_if.slave  bus,
  input  logic               psum_valid,
  output logic               busy,
  output logic               err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILT  = 3'd1,
    S_IFM   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Base addresses wrap modulo 2^ADDR_W, so truncating them up front is safe.
  localparam logic [ADDR_W-1:0] FILT_BASE_A = ADDR_W'(FILT_BASE);
  localparam logic [ADDR_W-1:0] IFM_BASE_A  = ADDR_W'(IFM_BASE);
  localparam logic [CNT_W-1:0]  FILT_LAST   = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  IFM_LAST    = CNT_W'(IFM_LEN - 1);
  localparam logic [CNT_W-1:0]  OUT_MAX     = CNT_W'(OUT_LEN);

  state_t             state;
  logic [CNT_W-1:0]   fcnt;
  logic [CNT_W-1:0]   icnt;
  logic [CNT_W-1:0]   pcnt;
  logic               token;
  logic               counting;
  logic               start_fire;
  logic               rd_fire;
  logic               done_fire;

  // Psums are legal while reads are in flight and while draining.
  assign counting   = (state == S_FILT) || (state == S_IFM) || (state == S_DRAIN);
  assign start_fire = bus.start_valid && bus.start_ready;
  assign rd_fire    = bus.rd_valid && bus.rd_ready;
  assign done_fire  = bus.done_valid && bus.done_ready;
  assign dbg_state  = state;

  // Sequencer: token acceptance, read issue, psum counting and done return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      bus.start_ready <= 1'b0;
      bus.done_valid  <= 1'b0;
      bus.done_data   <= 1'b0;
      bus.rd_valid    <= 1'b0;
      bus.rd_addr     <= '0;
      bus.rd_is_filt  <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
      fcnt            <= '0;
      icnt            <= '0;
      pcnt            <= '0;
      token           <= 1'b0;
    end else begin
      // Psum accounting runs beside the read phases; anything beyond
      // OUT_LEN or outside an active run is flagged and never counted.
      if (psum_valid) begin
        if (counting && (pcnt < OUT_MAX)) begin
          pcnt <= pcnt + CNT_W'(1);
        end else begin
          err <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          bus.start_ready <= 1'b1;
          if (start_fire) begin
            token           <= bus.start_data;
            fcnt            <= '0;
            icnt            <= '0;
            pcnt            <= '0;
            busy            <= 1'b1;
            bus.start_ready <= 1'b0;
            bus.rd_valid    <= 1'b1;
            bus.rd_is_filt  <= 1'b1;
            bus.rd_addr     <= FILT_BASE_A;
            state           <= S_FILT;
          end
        end

        S_FILT: begin
          if (rd_fire) begin
            fcnt <= fcnt + CNT_W'(1);
            if (fcnt == FILT_LAST) begin
              // First ifmap address follows with no bubble.
              bus.rd_is_filt <= 1'b0;
              bus.rd_addr    <= IFM_BASE_A;
              state          <= S_IFM;
            end else begin
              bus.rd_addr <= FILT_BASE_A + ADDR_W'(fcnt) + ADDR_W'(1);
            end
          end
        end

        S_IFM: begin
          if (rd_fire) begin
            icnt <= icnt + CNT_W'(1);
            if (icnt == IFM_LAST) begin
              bus.rd_valid <= 1'b0;
              state        <= S_DRAIN;
            end else begin
              bus.rd_addr <= IFM_BASE_A + ADDR_W'(icnt) + ADDR_W'(1);
            end
          end
        end

        S_DRAIN: begin
          // Uses the count as of the start of this cycle, so a run whose
          // psums are already complete still spends one cycle here.
          if (pcnt == OUT_MAX) begin
            bus.done_valid <= 1'b1;
            bus.done_data  <= token;
            state          <= S_DONE;
          end
        end

        S_DONE: begin
          if (done_fire) begin
            bus.done_valid  <= 1'b0;
            busy            <= 1'b0;
            bus.start_ready <= 1'b1;
            state           <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctrl_endpoint.sv
// Bench for pe_ctrl_endpoint: a default-parameter instance driven through
// directed runs and checked every cycle against a counter-level model, plus
// a second instance with an ifmap window that crosses the address wrap.
module tb_pe_ctrl_endpoint;

  localparam int F_LEN   = 5;
  localparam int I_LEN   = 25;
  localparam int O_LEN   = 21;
  localparam int F_BASE  = 0;
  localparam int I_BASE  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  always #5 clk = ~clk;

  pe_ctrl_endpoint_if #(.ADDR_W(8)) bus ();
  pe_ctrl_endpoint_if #(.ADDR_W(8)) wbus ();

  logic       psum_valid;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;
  logic       psum_w;
  logic       w_busy;
  logic       w_err;
  logic [2:0] w_state;

  pe_ctrl_endpoint dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .psum_valid (psum_valid),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  pe_ctrl_endpoint #(.IFM_BASE(250), .IFM_LEN(10), .OUT_LEN(3)) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (wbus),
    .psum_valid (psum_w),
    .busy       (w_busy),
    .err        (w_err),
    .dbg_state  (w_state)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the run as counts: reads accepted so far, psums counted, and
  // whether the done token is pending.
  bit m_active, m_done, m_err, m_sr, m_tok, m_dd;
  int m_issued, m_pcnt;

  function automatic bit m_rdv();
    return m_active && !m_done && (m_issued < F_LEN + I_LEN);
  endfunction

  function automatic bit m_drain();
    return m_active && !m_done && (m_issued == F_LEN + I_LEN);
  endfunction

  function automatic logic [7:0] m_addr();
    if (m_issued < F_LEN) return 8'((F_BASE + m_issued) % 256);
    return 8'((I_BASE + m_issued - F_LEN) % 256);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rdv, drn, act, dn, sr;
    int pc;
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_err = 0; m_sr = 0; m_tok = 0; m_dd = 0;
      m_issued = 0; m_pcnt = 0;
    end else begin
      rdv = m_rdv(); drn = m_drain(); act = m_active; dn = m_done; sr = m_sr; pc = m_pcnt;
      if (psum_valid) begin
        if (act && !dn && pc < O_LEN) m_pcnt = pc + 1;
        else m_err = 1;
      end
      if (!act) begin
        if (bus.start_valid && sr) begin
          m_active = 1; m_tok = bus.start_data; m_issued = 0; m_pcnt = 0; m_sr = 0;
        end else begin
          m_sr = 1;
        end
      end
      if (rdv && bus.rd_ready) m_issued++;
      if (drn && pc == O_LEN) begin m_done = 1; m_dd = m_tok; end
      if (dn && bus.done_ready) begin m_done = 0; m_active = 0; m_sr = 1; end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("start_ready", bus.start_ready, m_sr);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      chk("rd_valid", bus.rd_valid, m_rdv());
      if (m_rdv()) begin
        chk("rd_addr", bus.rd_addr, m_addr());
        chk("rd_is_filt", bus.rd_is_filt, m_issued < F_LEN);
      end
      chk("done_valid", bus.done_valid, m_done);
      if (m_done) chk("done_data", bus.done_data, m_dd);
    end
  end

  // ---------------- scoreboard of read requests ----------------
  logic [8:0] exp_q[$];
  logic [8:0] w_got[$];
  logic [8:0] w_exp [15] = '{9'h100, 9'h101, 9'h102, 9'h103, 9'h104,
                             9'h0FA, 9'h0FB, 9'h0FC, 9'h0FD, 9'h0FE, 9'h0FF,
                             9'h000, 9'h001, 9'h002, 9'h003};

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && chk_en && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_extra", {bus.rd_is_filt, bus.rd_addr}, 9'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("rd_order", {bus.rd_is_filt, bus.rd_addr}, e);
      end
    end
    if (rst_n && chk_en && wbus.rd_valid === 1'b1 && wbus.rd_ready === 1'b1)
      w_got.push_back({wbus.rd_is_filt, wbus.rd_addr});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_reads();
    for (int i = 0; i < F_LEN; i++) exp_q.push_back({1'b1, 8'(F_BASE + i)});
    for (int i = 0; i < I_LEN; i++) exp_q.push_back({1'b0, 8'(I_BASE + i)});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start_ready"}, bus.start_ready, 0);
    chk({tag, "_done_valid"}, bus.done_valid, 0);
    chk({tag, "_done_data"}, bus.done_data, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_rd_is_filt"}, bus.rd_is_filt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Offers a start token until accepted; returns one step after the accepting edge.
  task automatic send_start(input logic flag);
    bit hs = 0;
    int n = 0;
    bus.start_valid = 1'b1;
    bus.start_data  = flag;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.start_ready;
      tick();
      n++;
    end
    bus.start_valid = 1'b0;
    chk("start_accept", hs, 1);
  endtask

  // One full run. Edge 0 is the start acceptance; psums are driven on edges
  // ps_start .. ps_start+ps_n-1; done_ready is held low for done_hold cycles
  // after done_valid appears. lat = edge after which done_valid first shows.
  task automatic run_seq(input logic flag, input bit rd_toggle, input int ps_start,
                         input int ps_n, input int done_hold, output int lat);
    int cyc = 0;
    int done_seen = -1;
    bit fin = 0;
    bit hs;
    lat = -1;
    push_reads();
    send_start(flag);
    while (!fin && cyc < 400) begin
      bus.rd_ready = rd_toggle ? ((cyc % 2) == 0) : 1'b1;
      psum_valid   = (cyc + 1 >= ps_start) && (cyc + 1 < ps_start + ps_n);
      @(negedge clk);
      if (bus.done_valid && done_seen < 0) begin
        done_seen = cyc;
        lat = cyc;
      end
      bus.done_ready = (done_seen >= 0) && (cyc - done_seen >= done_hold);
      hs = bus.done_valid && bus.done_ready;
      tick();
      cyc++;
      if (hs) fin = 1;
    end
    psum_valid     = 1'b0;
    bus.done_ready = 1'b0;
    bus.rd_ready   = 1'b0;
    chk("run_completes", fin, 1);
    chk("reads_left", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit w_done;
    bus.start_valid = 0; bus.start_data = 0; bus.done_ready = 0; bus.rd_ready = 0;
    wbus.start_valid = 0; wbus.start_data = 0; wbus.done_ready = 0; wbus.rd_ready = 0;
    psum_valid = 0; psum_w = 0;

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1;
    chk_en = 1;

    // Wrap-around ifmap window on the second instance.
    wbus.rd_ready = 1; wbus.done_ready = 1; wbus.start_data = 1; wbus.start_valid = 1;
    w_done = 0;
    for (int n = 0; n < 80 && !w_done; n++) begin
      @(negedge clk);
      if (wbus.done_valid) w_done = 1;
      tick();
      if (w_busy) wbus.start_valid = 0;
      psum_w = w_busy && (n % 4 == 0);
    end
    psum_w = 0;
    wbus.start_valid = 0;
    chk("wrap_done", w_done, 1);
    chk("wrap_count", w_got.size(), 15);
    for (int i = 0; i < 15; i++)
      if (i < w_got.size()) chk("wrap_addr", w_got[i], w_exp[i]);

    // Back-to-back reads, psums during IFM: 1 + 30 + 1 edges to done_valid.
    run_seq(1'b1, 1'b0, 8, 21, 0, lat);
    chk("t1_latency", lat, 31);

    // rd_ready toggling: accepts on odd edges 1..59, done after edge 60.
    run_seq(1'b0, 1'b1, 8, 21, 0, lat);
    chk("t2_latency", lat, 60);

    // Late psums (edges 41..61) and done_ready held low 7 cycles.
    run_seq(1'b1, 1'b0, 41, 21, 7, lat);
    chk("t3_latency", lat, 62);

    // 22 psums: the extra one flags err, run still completes normally.
    run_seq(1'b0, 1'b0, 8, 22, 0, lat);
    chk("t4_latency", lat, 31);
    chk("t4_err", err, 1);

    // Psum while idle, then a clean run: err stays set.
    psum_valid = 1;
    tick();
    psum_valid = 0;
    run_seq(1'b1, 1'b0, 8, 21, 0, lat);
    chk("t5_latency", lat, 31);
    chk("t5_err_sticky", err, 1);
    chk("t5_done_data", bus.done_data, 1);

    // Asynchronous reset while the 3rd ifmap address is presented.
    push_reads();
    send_start(1'b1);
    bus.rd_ready = 1;
    repeat (7) tick();
    chk("pre_reset_addr", bus.rd_addr, 18);
    #2;
    rst_n = 0;
    #1;
    check_reset_vals("async");
    exp_q.delete();
    bus.rd_ready = 0;
    tick();
    rst_n = 1;
    run_seq(1'b0, 1'b0, 8, 21, 0, lat);
    chk("t6_latency", lat, 31);
    chk("t6_err_cleared", err, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
